// File: rtl/soc_spi_sram_responder.sv
// SoC word-SRAM port responder: turns each cs/we/addr request into one SPI transaction
// (cmd, 24-bit address, 32 data bits) against a serial SPI SRAM in sequential mode.
module soc_spi_sram_responder #(
    parameter int ADDR_W = 17
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        sram_cs,
    input  logic        sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_data_write,
    output logic [31:0] sram_data_read,
    output logic        sram_ack,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    // Memory words are little-endian by byte, while each byte goes out MSB first.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [63:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        phase_q, phase_d;
    logic        we_q, we_d;
    logic        cs_n_q, cs_n_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;

    logic [33:0] byte_addr;
    logic [23:0] spi_addr;
    logic        unused_addr_hi;

    assign byte_addr      = {sram_addr, 2'b00};
    assign spi_addr       = 24'(byte_addr[ADDR_W-1:0]);
    assign unused_addr_hi = ^byte_addr[33:ADDR_W];

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        we_d      = we_q;
        cs_n_d    = 1'b1;
        sck_d     = 1'b0;
        mosi_d    = 1'b0;
        ack_d     = 1'b0;
        rdata_d   = rdata_q;

        case (state_q)
            IDLE: begin
                if (sram_cs) begin
                    we_d      = sram_we;
                    tx_d      = {sram_we ? CMD_WRITE : CMD_READ, spi_addr,
                                 sram_we ? bswap32(sram_data_write) : 32'h0};
                    bit_cnt_d = 6'd0;
                    phase_d   = 1'b0;
                    cs_n_d    = 1'b0;
                    mosi_d    = tx_d[63];
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                cs_n_d = 1'b0;
                if (!phase_q) begin
                    phase_d = 1'b1;
                    sck_d   = 1'b1;
                    mosi_d  = mosi_q;
                end else begin
                    // Falling SCK: memory has had a full clk to drive MISO since the rising edge.
                    phase_d   = 1'b0;
                    rx_d      = {rx_q[30:0], spi_miso};
                    tx_d      = {tx_q[62:0], 1'b0};
                    bit_cnt_d = 6'(bit_cnt_q + 6'd1);
                    if (bit_cnt_q == 6'd63) begin
                        cs_n_d  = 1'b1;
                        ack_d   = 1'b1;
                        state_d = ACK;
                        if (!we_q) begin
                            rdata_d = bswap32(rx_d);
                        end
                    end else begin
                        mosi_d = tx_d[63];
                    end
                end
            end
            ACK: begin
                state_d = DONE;
            end
            default: begin
                // Swallows the cycle in which the initiator's cs is still high after ack.
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            phase_q   <= 1'b0;
            we_q      <= 1'b0;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            we_q      <= we_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign sram_data_read = rdata_q;
    assign sram_ack       = ack_q;
    assign spi_cs_n       = cs_n_q;
    assign spi_sck        = sck_q;
    assign spi_mosi       = mosi_q;

endmodule

// File: tb/tb_soc_spi_sram_responder.sv
// Bench for soc_spi_sram_responder: transaction-level model of the SPI frame plus directed requests.
module tb_soc_spi_sram_responder;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        sram_cs = 1'b0;
    logic        sram_we = 1'b0;
    logic [31:0] sram_addr = 32'h0;
    logic [31:0] sram_data_write = 32'h0;
    logic [31:0] sram_data_read;
    logic        sram_ack;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    always #5 clk = ~clk;

    soc_spi_sram_responder #(.ADDR_W(17)) dut (
        .clk             (clk),
        .i_rst_n         (i_rst_n),
        .sram_cs         (sram_cs),
        .sram_we         (sram_we),
        .sram_addr       (sram_addr),
        .sram_data_write (sram_data_write),
        .sram_data_read  (sram_data_read),
        .sram_ack        (sram_ack),
        .spi_cs_n        (spi_cs_n),
        .spi_sck         (spi_sck),
        .spi_mosi        (spi_mosi),
        .spi_miso        (spi_miso)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: m_t is the current cycle number counted from the accept edge.
    bit          m_active = 1'b0;
    int          m_t = 0;
    bit          m_we = 1'b0;
    logic [63:0] m_frame = '0;
    logic [63:0] m_resp = '0;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_rexp = '0;
    logic [31:0] m_ba = '0;
    logic [31:0] m_dw = '0;
    longint      cyc = 0;
    longint      acc_cyc = 0;
    logic [7:0]  stream [4];

    always @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_active = 1'b0;
            m_t      = 0;
            m_rdata  = '0;
        end else begin
            cyc++;
            if (m_active) begin
                if (m_t == 130) begin
                    m_active = 1'b0;
                end else begin
                    m_t++;
                    if (m_t == 129 && !m_we) m_rdata = m_rexp;
                end
            end else if (sram_cs) begin
                m_active = 1'b1;
                m_t      = 1;
                acc_cyc  = cyc;
                m_we     = sram_we;
                m_ba     = (sram_addr * 32'd4) % 32'h20000;
                for (int k = 0; k < 4; k++) begin
                    m_dw[31-8*k -: 8]  = sram_data_write[8*k +: 8];
                    m_rexp[8*k +: 8]   = stream[k];
                end
                m_frame = {sram_we ? 8'h02 : 8'h03, m_ba[23:0], sram_we ? m_dw : 32'h0};
                m_resp  = {40'hA5C35A3C96, stream[0], stream[1], stream[2], stream[3]};
            end
        end
    end

    logic [63:0] cap = '0;
    logic [63:0] last_cap = '0;
    int          last_lat = 0;
    int          dut_acks = 0;
    longint      last_ack_cyc = 0;

    always @(negedge clk) begin
        if (m_active && m_t <= 128) begin
            chk("shift_cs_n", spi_cs_n, 1'b0);
            chk("shift_sck", spi_sck, (m_t % 2 == 0));
            chk("shift_mosi", spi_mosi, m_frame[63-(m_t-1)/2]);
            chk("shift_ack", sram_ack, 1'b0);
            spi_miso = m_resp[63-(m_t-1)/2];
            if (m_t % 2 == 0) cap = {cap[62:0], spi_mosi};
        end else if (m_active && m_t == 129) begin
            chk("ack_pulse", sram_ack, 1'b1);
            chk("ack_cs_n", spi_cs_n, 1'b1);
            chk("ack_sck", spi_sck, 1'b0);
            spi_miso = 1'b0;
        end else begin
            chk("idle_cs_n", spi_cs_n, 1'b1);
            chk("idle_sck", spi_sck, 1'b0);
            chk("idle_ack", sram_ack, 1'b0);
            spi_miso = 1'b0;
        end
        chk("data_read", sram_data_read, m_rdata);
        if (sram_ack === 1'b1) begin
            dut_acks++;
            last_cap     = cap;
            last_lat     = int'(cyc - acc_cyc + 1);
            last_ack_cyc = cyc;
        end
    end

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_active) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: no accept within 20 cycles");
        end
    endtask

    task automatic wait_ack();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sram_ack === 1'b1) begin ok = 1'b1; break; end
        end
        #1;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ack_timeout: no ack within 300 cycles");
        end
    endtask

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] data);
        repeat (3) @(negedge clk);
        sram_cs = 1'b1; sram_we = we; sram_addr = addr; sram_data_write = data;
        wait_accept();
        sram_we = ~we; sram_addr = ~addr; sram_data_write = ~data;
        wait_ack();
        sram_cs = 1'b0;
    endtask

    task automatic set_stream(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        stream[0] = b0; stream[1] = b1; stream[2] = b2; stream[3] = b3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint ack1;
        int     a;
        bit     hit;
        set_stream(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cs_n", spi_cs_n, 1'b1);
        chk("rst_sck", spi_sck, 1'b0);
        chk("rst_mosi", spi_mosi, 1'b0);
        chk("rst_ack", sram_ack, 1'b0);
        chk("rst_data", sram_data_read, 32'h0);
        @(negedge clk); #2 i_rst_n = 1'b1;

        // Read of word 0x10.
        set_stream(8'h78, 8'h56, 8'h34, 8'h12);
        do_req(1'b0, 32'h10, 32'h0);
        chk("rd_cmd_addr", last_cap[63:32], 32'h03000040);
        chk("rd_mosi_data", last_cap[31:0], 32'h0);
        chk("rd_data", sram_data_read, 32'h12345678);
        chk("rd_latency", last_lat, 129);

        // Write of word 0x1.
        set_stream(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        do_req(1'b1, 32'h1, 32'hDEADBEEF);
        chk("wr_frame", last_cap, 64'h02000004EFBEADDE);
        chk("wr_data_kept", sram_data_read, 32'h12345678);
        chk("wr_latency", last_lat, 129);

        // cs held through ack/DONE with address changed after accept.
        set_stream(8'h11, 8'h22, 8'h33, 8'h44);
        repeat (3) @(negedge clk);
        sram_cs = 1'b1; sram_we = 1'b0; sram_addr = 32'h20;
        wait_accept();
        sram_addr = 32'h30;
        wait_ack();
        ack1 = last_ack_cyc;
        chk("hold_first_addr", last_cap[63:32], 32'h03000080);
        chk("hold_first_data", sram_data_read, 32'h44332211);
        wait_ack();
        sram_cs = 1'b0;
        chk("hold_second_addr", last_cap[63:32], 32'h030000C0);
        chk("hold_spacing", last_ack_cyc - ack1, 131);

        // Top of the word address range folds into 17 byte-address bits.
        set_stream(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        do_req(1'b0, 32'hFFFFFFFF, 32'h0);
        chk("max_addr", last_cap[63:32], 32'h0301FFFC);
        chk("max_addr_data", sram_data_read, 32'hDDCCBBAA);

        // Idle with sram_we toggling.
        a = dut_acks;
        repeat (20) begin
            @(negedge clk);
            sram_we = ~sram_we;
            sram_addr = sram_addr + 32'h5;
        end
        sram_we = 1'b0;
        chk("idle_no_ack", dut_acks, a);

        // Reset during bit 20 (phase 1, SCK high).
        repeat (3) @(negedge clk);
        sram_cs = 1'b1; sram_we = 1'b1; sram_addr = 32'h40; sram_data_write = 32'h01020304;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_active && m_t == 42) begin hit = 1'b1; break; end
        end
        chk("reach_bit20", hit, 1'b1);
        chk("bit20_sck_high", spi_sck, 1'b1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", spi_cs_n, 1'b1);
        chk("mid_rst_sck", spi_sck, 1'b0);
        chk("mid_rst_ack", sram_ack, 1'b0);
        chk("mid_rst_data", sram_data_read, 32'h0);
        sram_cs = 1'b0;
        a = dut_acks;
        repeat (2) @(negedge clk);
        #2 i_rst_n = 1'b1;
        repeat (150) @(negedge clk);
        chk("mid_rst_no_ack", dut_acks, a);

        set_stream(8'h78, 8'h56, 8'h34, 8'h12);
        do_req(1'b0, 32'h10, 32'h0);
        chk("post_rst_frame", last_cap[63:32], 32'h03000040);
        chk("post_rst_data", sram_data_read, 32'h12345678);
        chk("post_rst_latency", last_lat, 129);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
